// File: rtl/dm_dump_arbiter.sv
// Arbitrates the single data-memory port between the MEM stage and a word dump
// engine that streams a programmed range of 32-bit words over valid/ready.
module dm_dump_arbiter #(
  parameter int ADDR_W     = 11,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_stall,
  input  logic              dump_start,
  input  logic [ADDR_W-1:0] dump_base,
  input  logic [8:0]        dump_words,
  output logic              dump_busy,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [31:0]       dump_data,
  output logic [ADDR_W-1:0] dump_addr,
  output logic              dump_done,
  output logic              dm_en,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_wdata,
  input  logic [31:0]       dm_rdata
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0]  STARVE_LIM = CNT_W'(STARVE_MAX);
  localparam logic [ADDR_W-1:0] WORD_STEP  = ADDR_W'(4);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [9:0]        remain;
  logic [CNT_W-1:0]  starve_cnt;
  logic              cpu_wins;
  logic              dump_grant;

  // The CPU keeps the port in SCAN until it has used up its starvation budget.
  always_comb begin
    cpu_wins   = cpu_req && (starve_cnt < STARVE_LIM);
    dump_grant = (state == SCAN) && !cpu_wins;
  end

  // Memory port mux: the dump engine only drives it on its grant cycle.
  always_comb begin
    dm_wdata = cpu_wdata;
    if (dump_grant) begin
      dm_en   = 1'b1;
      dm_we   = 1'b0;
      dm_addr = ptr;
    end else begin
      dm_en   = cpu_req;
      dm_we   = cpu_we;
      dm_addr = cpu_addr;
    end
  end

  assign cpu_stall = cpu_req & dump_grant;
  assign cpu_rdata = dm_rdata;
  assign dump_busy = (state != IDLE);

  // Dump sequencer: range latch, read capture, output handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      remain     <= 10'd0;
      starve_cnt <= '0;
      dump_valid <= 1'b0;
      dump_data  <= 32'd0;
      dump_addr  <= '0;
      dump_done  <= 1'b0;
    end else begin
      dump_done <= 1'b0;
      case (state)
        IDLE: begin
          if (dump_start) begin
            ptr        <= {dump_base[ADDR_W-1:2], 2'b00};
            remain     <= (dump_words == 9'd0) ? 10'd512 : {1'b0, dump_words};
            starve_cnt <= '0;
            state      <= SCAN;
          end else begin
            state <= IDLE;
          end
        end
        SCAN: begin
          if (dump_grant) begin
            dump_data  <= dm_rdata;
            dump_addr  <= ptr;
            dump_valid <= 1'b1;
            starve_cnt <= '0;
            state      <= HOLD;
          end else begin
            starve_cnt <= starve_cnt + CNT_W'(1);
          end
        end
        HOLD: begin
          // dump_valid is always set in HOLD, so ready alone completes the handshake.
          if (dump_ready) begin
            dump_valid <= 1'b0;
            ptr        <= ptr + WORD_STEP;
            remain     <= remain - 10'd1;
            if (remain == 10'd1) begin
              state     <= IDLE;
              dump_done <= 1'b1;
            end else begin
              state <= SCAN;
            end
          end else begin
            state <= HOLD;
          end
        end
        default: begin
          state      <= IDLE;
          dump_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dm_dump_arbiter.sv
// Self-checking bench for dm_dump_arbiter: table of dump scenarios with random CPU
// traffic checked against a word-level reference memory, plus hand-written corner cases.
module tb_dm_dump_arbiter;

  localparam int STARVE_MAX = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [10:0] cpu_addr;
  logic [31:0] cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        dump_start;
  logic [10:0] dump_base;
  logic [8:0]  dump_words;
  logic        dump_busy, dump_valid, dump_ready, dump_done;
  logic [31:0] dump_data;
  logic [10:0] dump_addr;
  logic        dm_en, dm_we;
  logic [10:0] dm_addr;
  logic [31:0] dm_wdata, dm_rdata;

  logic [31:0] mem     [512];
  logic [31:0] ref_mem [512];
  logic        init_mem;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dm_dump_arbiter #(.ADDR_W(11), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dump_start(dump_start), .dump_base(dump_base), .dump_words(dump_words),
    .dump_busy(dump_busy), .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_data(dump_data), .dump_addr(dump_addr), .dump_done(dump_done),
    .dm_en(dm_en), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata)
  );

  function automatic logic [31:0] pat(input int i);
    if (i < 8) return 32'h1111_1111 * 32'(i);
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  // Data memory: combinational read, synchronous write, one-shot preload.
  assign dm_rdata = mem[dm_addr[10:2]];
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 512; i++) mem[i] <= pat(i);
    end else if (dm_en && dm_we) begin
      mem[dm_addr[10:2]] <= dm_wdata;
    end
  end

  typedef struct {
    logic [10:0] base;
    logic [8:0]  words;
    int          ready_pct;
    int          cpu_mode;   // 0 none, 1 reads anywhere, 2 reads/writes upper half
    int          cpu_pct;
    bit          poke;       // pulse dump_start again in the first SCAN cycle
    logic [10:0] exp_first;
    logic [10:0] exp_last;
    int          exp_n;
    int          exp_stall;  // -1: not fixed
    int          budget;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cpu_idle();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 11'h000; cpu_wdata = 32'd0;
  endtask

  task automatic chk_cpu_path();
    chk("dm_en_cpu", 32'(dm_en), 32'(cpu_req));
    if (cpu_req) begin
      chk("dm_we_cpu", 32'(dm_we), 32'(cpu_we));
      chk("dm_addr_cpu", 32'(dm_addr), 32'(cpu_addr));
      chk("dm_wdata_cpu", dm_wdata, cpu_wdata);
    end
  endtask

  task automatic run_dump(input vec_t v, output int n_got, output logic [10:0] first,
                          output logic [10:0] last, output int n_stall);
    logic [10:0] a0, e;
    int dones, run, exp_n;
    bit exp_valid, dgrant;
    a0 = {v.base[10:2], 2'b00};
    exp_n = (v.words == 9'd0) ? 512 : int'(v.words);
    n_got = 0; n_stall = 0; dones = 0; run = 0; exp_valid = 0; first = '0; last = '0;
    @(negedge clk);
    cpu_idle();
    dump_start = 1'b1; dump_base = v.base; dump_words = v.words; dump_ready = 1'b0;
    for (int c = 0; c < v.budget && dones == 0; c++) begin
      @(negedge clk);
      dump_start = v.poke && (c == 0);
      dump_base  = 11'h600;
      dump_words = 9'd5;
      cpu_req    = (v.cpu_mode != 0) && ($urandom_range(99) < v.cpu_pct);
      cpu_we     = (v.cpu_mode == 2) && ($urandom_range(1) == 1);
      cpu_addr   = (v.cpu_mode == 2) ? {1'b1, 8'($urandom_range(255)), 2'b00}
                                     : {9'($urandom_range(511)), 2'b00};
      cpu_wdata  = $urandom;
      dump_ready = ($urandom_range(99) < v.ready_pct);
      #1;
      if (exp_valid) chk("read_to_valid", 32'(dump_valid), 32'd1);
      exp_valid = 0;
      if (dump_done) begin
        dones++;
        chk("busy_in_done", 32'(dump_busy), 32'd0);
        chk("words_before_done", 32'(n_got), 32'(exp_n));
        chk("stall_idle", 32'(cpu_stall), 32'd0);
        chk_cpu_path();
      end else begin
        chk("busy", 32'(dump_busy), 32'd1);
        if (!dump_valid) begin
          // Read pending: CPU keeps the port until it has had STARVE_MAX grants.
          dgrant = !(cpu_req && run < STARVE_MAX);
          chk("stall_scan", 32'(cpu_stall), 32'(cpu_req && dgrant));
          if (dgrant) begin
            e = a0 + 11'(4 * n_got);
            chk("read_en", 32'(dm_en), 32'd1);
            chk("read_we", 32'(dm_we), 32'd0);
            chk("read_addr", 32'(dm_addr), 32'(e));
            run = 0;
            exp_valid = 1;
          end else begin
            run++;
            chk_cpu_path();
          end
        end else begin
          chk("stall_hold", 32'(cpu_stall), 32'd0);
          chk_cpu_path();
        end
        if (cpu_stall) n_stall++;
        if (dump_valid && dump_ready) begin
          e = a0 + 11'(4 * n_got);
          chk("dump_addr", 32'(dump_addr), 32'(e));
          chk("dump_data", dump_data, ref_mem[e[10:2]]);
          if (n_got == 0) first = dump_addr;
          last = dump_addr;
          n_got++;
        end
      end
      if (cpu_req && cpu_we && !cpu_stall) ref_mem[cpu_addr[10:2]] = cpu_wdata;
    end
    chk("done_pulses", 32'(dones), 32'd1);
    @(negedge clk);
    cpu_idle(); dump_ready = 1'b0; dump_start = 1'b0;
    #1;
    chk("done_one_cycle", 32'(dump_done), 32'd0);
    chk("idle_after_done", 32'(dump_busy), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_got, n_stall, diffs;
    logic [10:0] first, last;
    logic [31:0] held;
    bit done_seen;

    //                 base     words  rdy cpu pct poke first    last     n    stall budget
    tbl[0] = '{11'h000, 9'd8,   100, 0, 0,   0, 11'h000, 11'h01C, 8,   0,  200};
    tbl[1] = '{11'h7F9, 9'd3,   100, 0, 0,   0, 11'h7F8, 11'h000, 3,   0,  100};
    tbl[2] = '{11'h000, 9'd0,   100, 0, 0,   0, 11'h000, 11'h7FC, 512, 0,  1500};
    tbl[3] = '{11'h104, 9'd0,   60,  1, 50,  0, 11'h104, 11'h100, 512, -1, 8000};
    tbl[4] = '{11'h200, 9'd40,  70,  2, 60,  0, 11'h200, 11'h29C, 40,  -1, 1000};
    tbl[5] = '{11'h100, 9'd2,   100, 2, 100, 0, 11'h100, 11'h104, 2,   2,  100};
    tbl[6] = '{11'h3A0, 9'd20,  40,  2, 90,  0, 11'h3A0, 11'h3EC, 20,  -1, 1000};
    tbl[7] = '{11'h080, 9'd2,   100, 0, 0,   1, 11'h080, 11'h084, 2,   0,  100};

    for (int i = 0; i < 512; i++) ref_mem[i] = pat(i);
    rst = 1'b1; init_mem = 1'b1;
    cpu_idle(); dump_start = 1'b0; dump_base = '0; dump_words = '0; dump_ready = 1'b0;
    repeat (2) @(negedge clk);
    init_mem = 1'b0;
    cpu_req = 1'b1; cpu_addr = 11'h124;
    #1;
    chk("rst_busy", 32'(dump_busy), 32'd0);
    chk("rst_valid", 32'(dump_valid), 32'd0);
    chk("rst_done", 32'(dump_done), 32'd0);
    chk("rst_data", dump_data, 32'd0);
    chk("rst_addr", 32'(dump_addr), 32'd0);
    chk("rst_stall", 32'(cpu_stall), 32'd0);
    chk("rst_dm_en", 32'(dm_en), 32'd1);
    chk("rst_dm_addr", 32'(dm_addr), 32'h124);
    chk("rst_cpu_rdata", cpu_rdata, pat(32'h124 >> 2));
    @(negedge clk);
    rst = 1'b0; cpu_idle();

    // Held word is overwritten by the CPU while the consumer stalls.
    @(negedge clk);
    dump_start = 1'b1; dump_base = 11'h020; dump_words = 9'd2; dump_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); dump_start = 1'b0; #1;
      if (dump_valid) break;
    end
    chk("hold_valid", 32'(dump_valid), 32'd1);
    held = ref_mem[8];
    chk("hold_data0", dump_data, held);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 11'h020; cpu_wdata = 32'hDEAD_BEEF;
      #1;
      chk("hold_stall", 32'(cpu_stall), 32'd0);
      chk("hold_valid_k", 32'(dump_valid), 32'd1);
      chk("hold_data_k", dump_data, held);
      chk("hold_addr_k", 32'(dump_addr), 32'h020);
      chk("hold_dm_addr", 32'(dm_addr), 32'h020);
      chk("hold_dm_we", 32'(dm_we), 32'd1);
    end
    ref_mem[8] = 32'hDEAD_BEEF;
    cpu_idle();
    done_seen = 0;
    for (int c = 0; c < 12 && !done_seen; c++) begin
      @(negedge clk); dump_ready = 1'b1; #1;
      if (dump_done) done_seen = 1;
      if (dump_valid && dump_addr == 11'h020) chk("hold_data_final", dump_data, held);
      if (dump_valid && dump_addr == 11'h024) chk("hold_next_word", dump_data, ref_mem[9]);
    end
    chk("hold_done", 32'(done_seen), 32'd1);
    chk("hold_mem_written", mem[8], 32'hDEAD_BEEF);

    // Reset in the middle of HOLD abandons the dump silently.
    @(negedge clk);
    dump_start = 1'b1; dump_base = 11'h000; dump_words = 9'd4; dump_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); dump_start = 1'b0; #1;
      if (dump_valid) break;
    end
    chk("mid_valid", 32'(dump_valid), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(dump_valid), 32'd0);
    chk("mid_rst_busy", 32'(dump_busy), 32'd0);
    chk("mid_rst_data", dump_data, 32'd0);
    chk("mid_rst_addr", 32'(dump_addr), 32'd0);
    @(negedge clk);
    rst = 1'b0; dump_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      chk("mid_no_done", 32'(dump_done), 32'd0);
      chk("mid_idle", 32'(dump_busy), 32'd0);
    end

    for (int t = 0; t < 8; t++) begin
      run_dump(tbl[t], n_got, first, last, n_stall);
      chk($sformatf("vec%0d_count", t), 32'(n_got), 32'(tbl[t].exp_n));
      chk($sformatf("vec%0d_first", t), 32'(first), 32'(tbl[t].exp_first));
      chk($sformatf("vec%0d_last", t), 32'(last), 32'(tbl[t].exp_last));
      if (tbl[t].exp_stall >= 0)
        chk($sformatf("vec%0d_stalls", t), 32'(n_stall), 32'(tbl[t].exp_stall));
    end

    diffs = 0;
    for (int i = 0; i < 512; i++) if (mem[i] !== ref_mem[i]) diffs++;
    chk("mem_image", 32'(diffs), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
